// File: rtl/sw_key_debounce_if.sv
// sw_key_debounce_if
//   Bundles the switch bank and the key-event outputs of sw_key_debounce.
//   Signals:
//     sw        [11:0] raw switch bank, asynchronous to clk
//     key_valid        one-cycle pulse: accepted key event
//     key_code  [3:0]  code of the last accepted key, held until the next event
//     key_err          one-cycle pulse: a stable multi-switch chord was rejected
//     key_held         level, high while an accepted key remains pressed
//   Modports:
//     master - switch-bank side (drives sw, observes key outputs)
//     slave  - debouncer side (samples sw, drives key outputs)
interface sw_key_debounce_if;
   logic [11:0] sw;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_err;
   logic        key_held;

   modport master (output sw, input key_valid, key_code, key_err, key_held);
   modport slave  (input sw, output key_valid, key_code, key_err, key_held);
endinterface

// File: rtl/sw_key_debounce.sv
// sw_key_debounce
//   Synchronises and debounces the 12 one-hot front-panel switches and emits
//   one single-cycle key event per press, with a 4-bit key code
//   (sw[11-k] -> k for k = 0..9, sw[1] -> 4'hA, sw[0] -> 4'hB).
//   Stable chords with more than one switch set are rejected via key_err.
//   A full release must be debounced before the next key is accepted.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous, active-high reset
//     kif  - sw_key_debounce_if.slave (sw in; key_valid, key_code, key_err,
//            key_held out, all registered)
//   Build option:
//     KEY_REPEAT_EN - when defined, a held digit key (codes 0..9) re-pulses
//                     key_valid after REPEAT_DELAY cycles, then every
//                     REPEAT_PERIOD cycles, while the key stays held.
module sw_key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             rst,
   sw_key_debounce_if.slave kif
);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
      $error("sw_key_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
   end

   localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;

   state_t           state, state_nxt;
   logic [11:0]      sync1, sw_s;
   logic [11:0]      snap, snap_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             valid_q, valid_nxt;
   logic             err_q, err_nxt;
   logic             held_q, held_nxt;
   logic [3:0]       code_q, code_nxt;
   logic             snap_onehot;
   logic [3:0]       snap_code;

`ifdef KEY_REPEAT_EN
   localparam int unsigned      RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned      RPT_W    = $clog2(RPT_MAX);
   localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PER  = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
   logic             rpt_first, rpt_first_nxt;  // next repeat uses REPEAT_DELAY
   logic             rpt_en, rpt_en_nxt;        // held key is a repeatable digit
`endif

   // Clear-bit-trick one-hot test; snap is never zero while it is evaluated.
   assign snap_onehot = (snap != '0) && ((snap & (snap - 12'd1)) == '0);

   // Code is 11 minus the bit index for every switch.
   always_comb begin
      snap_code = '0;
      for (int unsigned i = 0; i < 12; i++) begin
         if (snap[i]) snap_code = 4'(11 - i);
      end
   end

   always_comb begin
      state_nxt = state;
      snap_nxt  = snap;
      cnt_nxt   = cnt;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      held_nxt  = held_q;
      code_nxt  = code_q;
`ifdef KEY_REPEAT_EN
      rpt_cnt_nxt   = rpt_cnt;
      rpt_first_nxt = rpt_first;
      rpt_en_nxt    = rpt_en;
`endif
      case (state)
         IDLE: begin
            if (sw_s != '0) begin
               snap_nxt  = sw_s;
               cnt_nxt   = '0;
               state_nxt = DB_PRESS;
            end
         end
         DB_PRESS: begin
            if (sw_s == '0) begin
               state_nxt = IDLE;
            end else if (sw_s != snap) begin
               snap_nxt = sw_s;
               cnt_nxt  = '0;
            end else if (cnt == CNT_LAST) begin
               if (snap_onehot) begin
                  valid_nxt = 1'b1;
                  code_nxt  = snap_code;
                  held_nxt  = 1'b1;
`ifdef KEY_REPEAT_EN
                  rpt_en_nxt    = (snap_code < 4'hA);
                  rpt_cnt_nxt   = '0;
                  rpt_first_nxt = 1'b1;
`endif
               end else begin
                  err_nxt = 1'b1;
`ifdef KEY_REPEAT_EN
                  rpt_en_nxt = 1'b0;
`endif
               end
               state_nxt = HELD;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HELD: begin
            if (sw_s == '0) begin
               cnt_nxt   = '0;
               state_nxt = DB_REL;
`ifdef KEY_REPEAT_EN
               // A release bounce restarts the repeat timing at REPEAT_PERIOD.
               rpt_cnt_nxt   = '0;
               rpt_first_nxt = 1'b0;
`endif
            end
`ifdef KEY_REPEAT_EN
            else if (rpt_en) begin
               if (rpt_cnt == (rpt_first ? RPT_DLY : RPT_PER)) begin
                  valid_nxt     = 1'b1;
                  rpt_cnt_nxt   = '0;
                  rpt_first_nxt = 1'b0;
               end else begin
                  rpt_cnt_nxt = rpt_cnt + 1'b1;
               end
            end
`endif
         end
         DB_REL: begin
            if (sw_s != '0) begin
               state_nxt = HELD;
            end else if (cnt == CNT_LAST) begin
               held_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= '0;
         sw_s    <= '0;
         state   <= IDLE;
         snap    <= '0;
         cnt     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         held_q  <= 1'b0;
         code_q  <= '0;
`ifdef KEY_REPEAT_EN
         rpt_cnt   <= '0;
         rpt_first <= 1'b0;
         rpt_en    <= 1'b0;
`endif
      end else begin
         sync1   <= kif.sw;
         sw_s    <= sync1;
         state   <= state_nxt;
         snap    <= snap_nxt;
         cnt     <= cnt_nxt;
         valid_q <= valid_nxt;
         err_q   <= err_nxt;
         held_q  <= held_nxt;
         code_q  <= code_nxt;
`ifdef KEY_REPEAT_EN
         rpt_cnt   <= rpt_cnt_nxt;
         rpt_first <= rpt_first_nxt;
         rpt_en    <= rpt_en_nxt;
`endif
      end
   end

   assign kif.key_valid = valid_q;
   assign kif.key_err   = err_q;
   assign kif.key_held  = held_q;
   assign kif.key_code  = code_q;

endmodule

// File: tb/tb_sw_key_debounce.sv
// tb_sw_key_debounce
//   Directed scenarios followed by random switch segments, compared cycle by
//   cycle against a run-length reference: a press is accepted once the same
//   non-zero pattern has been seen for DEBOUNCE_CYCLES+1 synchronised samples,
//   and a release once zero has been seen for DEBOUNCE_CYCLES+1 samples.
module tb_sw_key_debounce;
   localparam int unsigned D  = 4;
   localparam int unsigned RD = 20;
   localparam int unsigned RP = 8;

   logic clk = 1'b0;
   logic rst;

   sw_key_debounce_if kif ();

   sw_key_debounce #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif)
   );

   always #5 clk = ~clk;

   int unsigned checks     = 0;
   int unsigned errors     = 0;
   int unsigned dut_events = 0;
   int unsigned ref_events = 0;

   // Reference model state
   logic [11:0] pipe1, pipe2, last_s;
   int unsigned run_len, zero_run;
   bit          locked;
   logic        m_valid, m_err, m_held;
   logic [3:0]  m_code;
`ifdef KEY_REPEAT_EN
   bit          rep_ok, rep_first;
   int unsigned rep_t;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] code_of(input logic [11:0] x);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 12; i++) if (x[i]) c = 4'(11 - i);
      return c;
   endfunction

   task automatic ref_reset();
      pipe1 = '0; pipe2 = '0; last_s = '0;
      run_len = 0; zero_run = 0; locked = 0;
      m_valid = 0; m_err = 0; m_held = 0; m_code = '0;
`ifdef KEY_REPEAT_EN
      rep_ok = 0; rep_first = 0; rep_t = 0;
`endif
   endtask

   // Called once per rising edge with the switch value seen at that edge.
   task automatic ref_step(input bit r);
      logic [11:0] x;
      if (r) begin
         ref_reset();
         return;
      end
      m_valid = 0;
      m_err   = 0;
      x     = pipe2;          // value the debouncer evaluates at this edge
      pipe2 = pipe1;
      pipe1 = kif.sw;
      if (x == last_s) run_len++;
      else run_len = 1;
      last_s = x;
      if (!locked) begin
         if (x != '0 && run_len == D + 1) begin
            locked   = 1;
            zero_run = 0;
            if ($countones(x) == 1) begin
               m_valid = 1;
               m_code  = code_of(x);
               m_held  = 1;
`ifdef KEY_REPEAT_EN
               rep_ok = (m_code < 4'd10); rep_t = 0; rep_first = 1;
`endif
            end else begin
               m_err = 1;
`ifdef KEY_REPEAT_EN
               rep_ok = 0;
`endif
            end
         end
      end else if (x == '0) begin
         zero_run++;
`ifdef KEY_REPEAT_EN
         rep_t = 0; rep_first = 0;
`endif
         if (zero_run == D + 1) begin
            locked = 0;
            m_held = 0;
         end
      end else if (zero_run != 0) begin
         zero_run = 0;
      end else begin
`ifdef KEY_REPEAT_EN
         if (rep_ok) begin
            rep_t++;
            if (rep_t == (rep_first ? RD : RP)) begin
               m_valid = 1; rep_t = 0; rep_first = 0;
            end
         end
`endif
      end
   endtask

   // Starts and ends on a falling edge.
   task automatic step(input logic [11:0] v, input bit r);
      kif.sw = v;
      rst    = r;
      if (r) begin
         #1;
         check("rst_valid", kif.key_valid, 0);
         check("rst_err",   kif.key_err,   0);
         check("rst_held",  kif.key_held,  0);
         check("rst_code",  kif.key_code,  0);
      end
      @(posedge clk);
      ref_step(r);
      @(negedge clk);
      check("key_valid", kif.key_valid, m_valid);
      check("key_err",   kif.key_err,   m_err);
      check("key_held",  kif.key_held,  m_held);
      check("key_code",  kif.key_code,  m_code);
      if (kif.key_valid) dut_events++;
      if (m_valid) ref_events++;
   endtask

   initial begin
      kif.sw = '0;
      rst    = 1'b1;
      ref_reset();
      @(negedge clk);
      repeat (2) step('0, 1'b1);

      // Single digit press and release
      repeat (10) step(12'h020, 1'b0);
      repeat (10) step(12'h000, 1'b0);
      // Bouncing press, then stable
      repeat (5) begin
         step(12'h400, 1'b0); step(12'h400, 1'b0);
         step(12'h000, 1'b0); step(12'h000, 1'b0);
      end
      repeat (10) step(12'h400, 1'b0);
      repeat (10) step(12'h000, 1'b0);
      // Chord rejected, then a clean key
      repeat (10) step(12'h0C0, 1'b0);
      repeat (10) step(12'h000, 1'b0);
      repeat (10) step(12'h004, 1'b0);
      repeat (10) step(12'h000, 1'b0);
      // Clear keys; extra switch while held is ignored
      repeat (10) step(12'h002, 1'b0);
      repeat (10) step(12'h802, 1'b0);
      repeat (10) step(12'h000, 1'b0);
      repeat (10) step(12'h001, 1'b0);
      repeat (10) step(12'h000, 1'b0);
      // Reset in the middle of a press debounce
      repeat (5) step(12'h080, 1'b0);
      step(12'h080, 1'b1);
      repeat (12) step(12'h080, 1'b0);
      repeat (10) step(12'h000, 1'b0);
      // Long hold (auto-repeat when enabled), with a release bounce
      repeat (75) step(12'h080, 1'b0);
      repeat (2) step(12'h000, 1'b0);
      repeat (20) step(12'h080, 1'b0);
      repeat (10) step(12'h000, 1'b0);

      // Random segments
      for (int s = 0; s < 250; s++) begin
         int unsigned kind;
         int unsigned len;
         logic [11:0] v;
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 2 * D + 4);
         case (kind)
            0, 1, 2:    v = '0;
            3, 4, 5, 6: v = 12'd1 << $urandom_range(0, 11);
            7:          v = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
            8:          v = 12'($urandom);
            default: begin
               v   = 12'd1 << $urandom_range(0, 11);
               len = $urandom_range(20, 60);
            end
         endcase
         if ($urandom_range(0, 39) == 0) step(v, 1'b1);
         repeat (len) step(v, 1'b0);
      end
      repeat (12) step('0, 1'b0);

      check("event_count", dut_events, ref_events);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sw_key_debounce.md
Name: sw_key_debounce

Overview:
- Upstream input stage for the calculator datapath and LCD formatter.
- Synchronises and debounces the 12 one-hot front-panel switches.
- Emits exactly one clean single-cycle key event per press, carrying a 4-bit key code, so downstream operand capture counts presses rather than clock cycles.
- Multi-switch chords are rejected and reported as errors.

Parameters:
- DEBOUNCE_CYCLES, 50000: number of clk cycles the switch pattern must hold stable to be accepted, for both press and release. Legal range ≥2.
- REPEAT_DELAY, 25000000: clk cycles from the first event to the first auto-repeat. Used only with KEY_REPEAT_EN.
- REPEAT_PERIOD, 5000000: clk cycles between successive auto-repeats. Used only with KEY_REPEAT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sw  input  12  raw switch bank, asynchronous to clk
- key_valid  output  1  one-cycle pulse: accepted key event
- key_code  output  4  code of the last accepted key; held until the next event
- key_err  output  1  one-cycle pulse: a stable pattern with more than one bit set was rejected
- key_held  output  1  level, high while an accepted key remains pressed

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high. While rst is high, all of the following are 0: sync flops, snapshot, counter, key_valid, key_code, key_err, key_held. State is IDLE.
- Input sync: 2-flop synchroniser on all 12 bits; sw_s is the second stage.
- Key code map:
  - sw[11-k] → code k, for k = 0..9 (sw[11]=0 … sw[2]=9).
  - sw[1] → 4'hA (clear entry).
  - sw[0] → 4'hB (all clear).
- FSM states:
  - IDLE: if sw_s != 0, then snap ← sw_s, cnt ← 0, go to DB_PRESS.
  - DB_PRESS:
    - If sw_s == 0, go to IDLE (glitch discarded, no event).
    - Else if sw_s != snap, then snap ← sw_s, cnt ← 0 (restart).
    - Else if cnt == DEBOUNCE_CYCLES-1:
      - If snap is one-hot: key_valid ← 1 and key_code ← map(snap) for one cycle, key_held ← 1.
      - Otherwise: key_err ← 1 for one cycle, and key_code is unchanged.
      - In both cases go to HELD.
    - Else cnt ← cnt+1.
  - HELD:
    - If sw_s == 0, then cnt ← 0, go to DB_REL.
    - Pattern changes while not all-zero are ignored. The user must release fully before the next key is accepted.
  - DB_REL:
    - If sw_s != 0, go to HELD (bounce on release).
    - Else if cnt == DEBOUNCE_CYCLES-1, then key_held ← 0, go to IDLE.
    - Else cnt ← cnt+1.
- Latency: with sw changing once just before edge E0 and then stable, key_valid is high during the cycle following edge E0+DEBOUNCE_CYCLES+2.
- Outputs: all registered. key_valid and key_err are never high in the same cycle and never high for two consecutive cycles, except for repeats under KEY_REPEAT_EN.
- Counter: sized as $clog2 of the largest count needed, and never wraps. It saturates at the compare value because the state exits there.
- Reset asserted mid-press or mid-release aborts the operation immediately. No event is emitted after reset deassertion until a fresh full debounce completes.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- When defined:
  - In HELD with a valid one-hot key, a repeat counter starts at the accepted event.
  - key_valid re-pulses with the same key_code after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles, while still in HELD.
  - Codes 4'hA and 4'hB never repeat.
  - The repeat counter clears on entry to DB_REL. If the FSM returns to HELD, the count resumes from 0 toward REPEAT_PERIOD.
  - No repeats follow a key_err.
- When undefined: exactly one key_valid per press, and the repeat logic is absent.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
1. Reset then hold sw=12'h020 (digit 6) → key_valid single pulse with key_code=6 after edge E0+6; key_held=1; release → key_held=0 after 6 cycles.
2. sw toggles 12'h400/0 every 2 cycles for 20 cycles, then holds 12'h400 → no event during toggling; exactly one key_valid with code=1 after the stable debounce.
3. Hold sw=12'h0C0 → key_err one pulse, key_valid stays 0, key_code unchanged; release and press 12'h004 → key_valid with code=9.
4. Press 12'h002 → code=4'hA; while held, add 12'h800 → no event; release all, press 12'h001 → code=4'hB.
5. rst pulse while in DB_PRESS (cnt=2) → all outputs 0 immediately; keep sw held → a full fresh debounce occurs before key_valid.
6. KEY_REPEAT_EN, hold 12'h080 for 60 cycles after the first event → pulses at +0, +20, +28, +36, +44, +52, all with code=4.
